// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: register-index constants and the common
// address and word types used by the register file, the ALU and later blocks.
package legv8_pkg;

  localparam logic [4:0] XZR_IDX  = 5'd31;  // zero register, has no storage
  localparam int         NUM_REGS = 32;     // architectural registers incl. XZR
  localparam int         DATA_W   = 64;     // native datapath width

  typedef logic [4:0]        reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the LEGv8 register file.
//   addr     : register index to read (31 = XZR)
//   regs     : stored contents of X0..X30
//   wr_addr  : destination address of the write in flight
//   wr_data  : data of the write in flight
//   wr_en    : write enable of the write in flight
//   rd_data  : read result, feeds one ALU operand input
// XZR takes priority over everything, then the same-cycle bypass (when
// BYPASS != 0), then the stored value.
module regfile_read_port
  import legv8_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int BYPASS = 1
) (
  input  reg_addr_t          addr,
  input  logic [WIDTH-1:0]   regs [NUM_REGS-1],
  input  reg_addr_t          wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               wr_en,
  output logic [WIDTH-1:0]   rd_data
);

  logic             bypass_hit;
  logic [WIDTH-1:0] stored;

  // The XZR guard on the index keeps the 31-entry array access in range.
  always_comb begin
    stored = '0;
    if (addr != XZR_IDX) stored = regs[addr];
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      // A write to XZR is not a real write, so it can never be forwarded.
      assign bypass_hit = wr_en && (wr_addr != XZR_IDX) && (wr_addr == addr);
    end else begin : g_no_bypass
      logic unused_wr;
      assign unused_wr  = ^{wr_addr, wr_data, wr_en};
      assign bypass_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    rd_data = stored;
    if (addr == XZR_IDX)  rd_data = '0;
    else if (bypass_hit)  rd_data = wr_data;
  end

endmodule

// File: rtl/regfile_legv8.sv
// 32 x WIDTH LEGv8 general-purpose register file, two read ports, one write.
//   clock    : single clock, writes on the rising edge
//   reset_n  : asynchronous active-low reset, clears X0..X30
//   SA, SB   : read addresses for ports A and B
//   DA, D, W : write address, write data, write enable
//   A, B     : combinational read data (ALU operands)
// X31 (XZR) has no storage: it reads zero and swallows writes.
module regfile_legv8
  import legv8_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int BYPASS = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       SA,
  input  logic [4:0]       SB,
  input  logic [4:0]       DA,
  input  logic [WIDTH-1:0] D,
  input  logic             W,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B
);

  localparam int NUM_STORED = NUM_REGS - 1;

  logic [WIDTH-1:0] x_reg [NUM_STORED];

  // Reset clears the whole array and overrides any write on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STORED; i++) x_reg[i] <= '0;
    end else if (W && (DA != XZR_IDX)) begin
      x_reg[DA] <= D;
    end
  end

  reg_addr_t        rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = SA;
  assign rd_addr[1] = SB;
  assign A          = rd_data[0];
  assign B          = rd_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      regfile_read_port #(
        .WIDTH  (WIDTH),
        .BYPASS (BYPASS)
      ) u_port (
        .addr    (rd_addr[gi]),
        .regs    (x_reg),
        .wr_addr (DA),
        .wr_data (D),
        .wr_en   (W),
        .rd_data (rd_data[gi])
      );
    end
  endgenerate

endmodule
